// File: rtl/rv_imem_resp.sv
// rv_imem_resp: instruction-memory responder with wait states, fault flag and program-load port
module rv_imem_resp #(
  parameter int ADDR_WIDTH = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter logic [INSTR_WIDTH-1:0] FAULT_INSTR = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  input  logic [ADDR_WIDTH-1:0]  req_addr_i,
  output logic                   req_ready_o,
  output logic                   rsp_valid_o,
  output logic [INSTR_WIDTH-1:0] rsp_instr_o,
  output logic                   rsp_fault_o,
  input  logic                   rsp_ready_i,
  input  logic                   prog_we_i,
  input  logic [ADDR_WIDTH-1:0]  prog_addr_i,
  input  logic [INSTR_WIDTH-1:0] prog_data_i
);
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WLOAD = CW'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [INSTR_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx;
  logic accept, fault, prog_ok, direct, unused_bits;
  assign unused_bits = ^prog_addr_i[1:0];
  // Full-width compares so high address bits can never alias into the array
  assign fault = (|req_addr_i[1:0]) || ((req_addr_i >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));
  assign prog_ok = (prog_addr_i >> 2) < ADDR_WIDTH'(DEPTH_WORDS);
  assign accept = (state == IDLE) && req_valid_i && !prog_we_i;
  assign direct = fault || (WAIT_CYCLES == 0);
  assign req_ready_o = (state == IDLE) && !prog_we_i && !rst;
  assign rsp_valid_o = (state == RESP);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (accept) begin
      state_n = direct ? RESP : WAIT;
      cnt_n = direct ? '0 : WLOAD;
    end else if (state == WAIT) begin
      state_n = (cnt == '0) ? RESP : WAIT;
      cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
    end else if (state == RESP && rsp_ready_i) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      rsp_instr_o <= '0;
      rsp_fault_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        idx <= req_addr_i[IW+1:2];
        rsp_fault_o <= fault;
        rsp_instr_o <= fault ? FAULT_INSTR : (WAIT_CYCLES == 0 ? mem[req_addr_i[IW+1:2]] : rsp_instr_o);
      end else if (state == WAIT && cnt == '0) begin
        rsp_instr_o <= mem[idx];
        rsp_fault_o <= 1'b0;
      end
    end
  end
  // Writes only land in IDLE, where they also block request acceptance
  always_ff @(posedge clk)
    if (!rst && state == IDLE && prog_we_i && prog_ok)
      mem[prog_addr_i[IW+1:2]] <= prog_data_i;
endmodule

// File: tb/tb_rv_imem_resp.sv
// tb_rv_imem_resp: scoreboard bench for a WAIT_CYCLES=1 and a WAIT_CYCLES=0 responder
module tb_rv_imem_resp;
  logic clk, rst;
  logic req_valid [2];
  logic [63:0] req_addr [2];
  logic req_ready [2];
  logic rsp_valid [2];
  logic [31:0] rsp_instr [2];
  logic rsp_fault [2];
  logic rsp_ready [2];
  logic prog_we [2];
  logic [63:0] prog_addr [2];
  logic [31:0] prog_data [2];
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  logic [32:0] e0, e1;
  logic [31:0] words [4];
  int checks = 0, passed = 0;
  int na, k, tv [4];
  logic acc, seen;

  rv_imem_resp #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid[0]), .req_addr_i(req_addr[0]),
    .req_ready_o(req_ready[0]), .rsp_valid_o(rsp_valid[0]), .rsp_instr_o(rsp_instr[0]),
    .rsp_fault_o(rsp_fault[0]), .rsp_ready_i(rsp_ready[0]), .prog_we_i(prog_we[0]),
    .prog_addr_i(prog_addr[0]), .prog_data_i(prog_data[0]));
  rv_imem_resp #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid[1]), .req_addr_i(req_addr[1]),
    .req_ready_o(req_ready[1]), .rsp_valid_o(rsp_valid[1]), .rsp_instr_o(rsp_instr[1]),
    .rsp_fault_o(rsp_fault[1]), .rsp_ready_i(rsp_ready[1]), .prog_we_i(prog_we[1]),
    .prog_addr_i(prog_addr[1]), .prog_data_i(prog_data[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL rsp0_unexpected: got %0h expected no response", rsp_instr[0]);
      end else begin
        e0 = q0.pop_front();
        chk("rsp0_instr", 64'(rsp_instr[0]), 64'(e0[31:0]));
        chk("rsp0_fault", 64'(rsp_fault[0]), 64'(e0[32]));
      end
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) begin
        checks++;
        $display("FAIL rsp1_unexpected: got %0h expected no response", rsp_instr[1]);
      end else begin
        e1 = q1.pop_front();
        chk("rsp1_instr", 64'(rsp_instr[1]), 64'(e1[31:0]));
        chk("rsp1_fault", 64'(rsp_fault[1]), 64'(e1[32]));
      end
    end
  end

  task automatic prog(input int d, input logic [63:0] a, input logic [31:0] v);
    prog_we[d] = 1; prog_addr[d] = a; prog_data[d] = v;
    @(posedge clk); #1;
    prog_we[d] = 0;
  endtask

  task automatic fetch(input int d, input logic [63:0] a, input logic [31:0] ins, input logic f,
                       input int lat, input int hold);
    int n;
    if (d == 0) q0.push_back({f, ins}); else q1.push_back({f, ins});
    req_valid[d] = 1; req_addr[d] = a; rsp_ready[d] = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[d] = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[d] && n < 20);
    chk("latency", 64'(n), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", 64'(rsp_valid[d]), 64'd1);
      chk("bp_instr", 64'(rsp_instr[d]), 64'(ins));
      @(posedge clk); #1;
    end
    if (hold > 0) begin rsp_ready[d] = 1; @(negedge clk); end
    @(negedge clk);
    chk("ready_back", 64'(req_ready[d]), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    words[0] = 32'h00500093; words[1] = 32'h00A00113; words[2] = 32'h002081B3; words[3] = 32'h00000063;
    rst = 1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_addr[d] = 0; rsp_ready[d] = 1; prog_we[d] = 0; prog_addr[d] = 0; prog_data[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_instr", 64'(rsp_instr[0]), 64'd0);
    chk("rst_fault", 64'(rsp_fault[0]), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      prog(0, 64'(i * 4), words[i]);
      prog(1, 64'(i * 4), words[i]);
    end
    fetch(0, 64'h8, 32'h002081B3, 0, 2, 0);
    fetch(0, 64'h6, 32'h00000013, 1, 1, 0);
    fetch(0, 64'h1000, 32'h00000013, 1, 1, 0);
    fetch(0, 64'h8000_0000_0000_0008, 32'h00000013, 1, 1, 0);
    fetch(0, 64'h4, 32'h00A00113, 0, 2, 5);
    prog_we[0] = 1; prog_addr[0] = 0; prog_data[0] = 32'hDEADBEEF;
    req_valid[0] = 1; req_addr[0] = 0;
    @(negedge clk);
    chk("prog_blocks_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    prog_we[0] = 0; req_valid[0] = 0;
    @(negedge clk);
    chk("not_taken_ready", 64'(req_ready[0]), 64'd1);
    chk("not_taken_valid", 64'(rsp_valid[0]), 64'd0);
    @(posedge clk); #1;
    fetch(0, 64'h0, 32'hDEADBEEF, 0, 2, 0);
    q0.push_back({1'b0, 32'h002081B3});
    req_valid[0] = 1; req_addr[0] = 64'h8;
    @(posedge clk); #1;
    req_valid[0] = 0;
    prog_we[0] = 1; prog_addr[0] = 64'h4; prog_data[0] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("wait_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    prog_we[0] = 0;
    repeat (2) @(posedge clk); #1;
    fetch(0, 64'h4, 32'h00A00113, 0, 2, 0);
    req_valid[0] = 1; req_addr[0] = 64'h0;
    @(posedge clk); #1;
    req_valid[0] = 0; rst = 1;
    @(negedge clk);
    chk("rst_wait_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1;
    end
    chk("abandoned_no_valid", 64'(seen), 64'd0);
    chk("abandoned_instr", 64'(rsp_instr[0]), 64'd0);
    chk("abandoned_fault", 64'(rsp_fault[0]), 64'd0);
    @(posedge clk); #1;
    fetch(0, 64'h0, 32'hDEADBEEF, 0, 2, 0);
    fetch(1, 64'hC, 32'h00000063, 0, 1, 0);
    fetch(1, 64'h2, 32'h00000013, 1, 1, 0);
    for (int i = 0; i < 4; i++) q1.push_back({1'b0, words[i]});
    na = 0; k = 0;
    req_valid[1] = 1; req_addr[1] = 0; rsp_ready[1] = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rsp_valid[1] && k < 4) begin tv[k] = c; k++; end
      acc = req_valid[1] && req_ready[1];
      @(posedge clk); #1;
      if (acc) begin
        na++;
        req_addr[1] = 64'(na * 4);
        if (na == 4) req_valid[1] = 0;
      end
    end
    chk("stream_count", 64'(k), 64'd4);
    for (int i = 1; i < 4; i++) chk("stream_gap", 64'(tv[i] - tv[i-1]), 64'd2);
    repeat (3) @(posedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/rv_imem_resp.md
# rv_imem_resp

Instruction-memory responder for the single-cycle RISC-V core: the slave end of the instruction-fetch address interface driven by the program counter. It accepts a byte address through a valid/ready request channel and reads a 32-bit instruction from an internal word array after a configurable number of wait states. The result is returned on a valid/ready response channel, with a fault flag for misaligned or out-of-range fetches. A program-load write port fills the array at boot and from the bench.

## Interface
- ADDR_WIDTH, 64, byte-address width, matching the PC address width
- INSTR_WIDTH, 32, instruction width
- DEPTH_WORDS, 1024, number of INSTR_WIDTH words in the array
- WAIT_CYCLES, 1, wait states between request acceptance and response (0 allowed)
- FAULT_INSTR, 32'h00000013, instruction returned on fault (addi x0,x0,0)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous and active-high
- req_valid_i  input  1  fetch request valid
- req_addr_i  input  ADDR_WIDTH  fetch byte address
- req_ready_o  output  1  responder can accept a request
- rsp_valid_o  output  1  response valid
- rsp_instr_o  output  INSTR_WIDTH  fetched instruction
- rsp_fault_o  output  1  1 = misaligned or out-of-range fetch
- rsp_ready_i  input  1  consumer accepts the response
- prog_we_i  input  1  program-load write enable
- prog_addr_i  input  ADDR_WIDTH  program-load byte address; bits [1:0] ignored
- prog_data_i  input  INSTR_WIDTH  program-load data

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = ~prog_we_i.
  - A request is accepted when req_valid_i & req_ready_o at a rising edge. The responder captures the address and evaluates the fault condition.
- Fault condition: req_addr_i[1:0] != 0, or word index (req_addr_i >> 2) >= DEPTH_WORDS. Comparison is at full ADDR_WIDTH, with no truncation.
- Transitions on acceptance:
  - Faulting request: go to RESP with rsp_instr_o = FAULT_INSTR and rsp_fault_o = 1. No wait states.
  - Non-fault request with WAIT_CYCLES = 0: go to RESP.
  - Otherwise: load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 0, read the array at the captured index, register the word into rsp_instr_o, clear rsp_fault_o, and go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_instr_o and rsp_fault_o stay stable.
  - On rsp_valid_o & rsp_ready_i at an edge, return to IDLE.
- Only one transaction is outstanding at a time. req_ready_o is 0 in WAIT and RESP.
- Program load:
  - Writes are accepted only in IDLE, to word prog_addr_i >> 2.
  - Writes with index >= DEPTH_WORDS are dropped.
  - prog_we_i in WAIT/RESP is ignored.
  - A write in IDLE blocks request acceptance in that cycle, so reads never race writes.
- Array contents are not reset.

## Timing
- While rst = 1 and on the cycle after: state = IDLE, rsp_valid_o = 0, rsp_instr_o = 0, rsp_fault_o = 0, wait counter = 0. req_ready_o = 0 while rst is high.
- Reset mid-transaction (WAIT or RESP) abandons the transaction silently; no response is produced.
- Latency: request accepted at edge E. rsp_valid_o rises after edge E+WAIT_CYCLES for non-fault requests, and after edge E for faults.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles with rsp_ready_i held at 1. There is no back-to-back acceptance: req_ready_o rises the cycle after the response handshake.
- Backpressure: rsp_valid_o stays at 1 indefinitely while rsp_ready_i = 0, with outputs unchanged.
- req_addr_i and req_valid_i are ignored outside IDLE.

## Test plan
- Reset, load words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000063. Fetch 0x8 with WAIT_CYCLES = 1 and rsp_ready_i = 1 -> rsp_valid_o rises 2 edges after acceptance, rsp_instr_o = 32'h002081B3, rsp_fault_o = 0, req_ready_o returns to 1 one cycle later.
- Fetch 0x6 -> response in the cycle after acceptance with rsp_fault_o = 1 and rsp_instr_o = 32'h00000013. Fetch DEPTH_WORDS*4 = 0x1000 -> same fault response.
- Fetch 0x4 with rsp_ready_i held at 0 for 5 cycles -> rsp_valid_o = 1 and rsp_instr_o = 32'h00A00113 stable for all 5 cycles. Handshake on the 6th, then IDLE.
- prog_we_i = 1 (addr 0x0, data 32'hDEADBEEF) with req_valid_i = 1 in the same cycle -> req_ready_o = 0 and the request is not taken. Request accepted next cycle returns 32'hDEADBEEF. prog_we_i in WAIT to 0x4 -> word 1 unchanged.
- Assert rst during WAIT -> no rsp_valid_o pulse, all outputs 0. A subsequent fetch of 0x0 completes normally.
- WAIT_CYCLES = 0 build: fetch 0xC -> rsp_valid_o in the cycle after acceptance with 32'h00000063. Issue 4 sequential fetches 0x0..0xC with rsp_ready_i = 1 -> one response every 2 cycles, in order.
